// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared constants and elaboration-time helpers for the
// parametrised serial pattern detector.
//   PAT_W_MAX       largest supported pattern length
//   IDX_W           width of prefix indices inside the tables
//   fail_tbl_t      KMP failure table, entry k = F[k]
//   seq_det_prog_w  width needed to hold a prefix length 0..pat_w
//   seq_det_order   pattern re-ordered so bit j is the j-th bit received
//   seq_det_fail    KMP failure table for a pattern
package seq_det_pkg;

    localparam int PAT_W_MAX = 16;
    localparam int IDX_W     = 5;

    typedef logic [31:0][IDX_W-1:0] fail_tbl_t;

    function automatic int seq_det_prog_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

    // PATTERN is stored MSB-first on the wire; flip it into stream order.
    function automatic logic [31:0] seq_det_order(input logic [PAT_W_MAX-1:0] pattern,
                                                  input int pat_w);
        logic [31:0] r;
        r = '0;
        for (int j = 0; j < PAT_W_MAX; j++) begin
            if (j < pat_w) r[j] = pattern[pat_w-1-j];
        end
        return r;
    endfunction

    // F[k] = length of the longest proper border of the first k pattern bits.
    // The inner loop is a bounded stand-in for the usual while loop: once its
    // condition goes false it stays false for the remaining iterations.
    function automatic fail_tbl_t seq_det_fail(input logic [PAT_W_MAX-1:0] pattern,
                                               input int pat_w);
        fail_tbl_t   f;
        logic [31:0] p;
        int          k;
        f = '0;
        p = seq_det_order(pattern, pat_w);
        k = 0;
        for (int i = 1; i < PAT_W_MAX; i++) begin
            if (i < pat_w) begin
                for (int n = 0; n < PAT_W_MAX; n++) begin
                    if (k > 0 && p[i] != p[k]) k = int'(f[k]);
                end
                if (p[i] == p[k]) k++;
                f[i+1] = IDX_W'(k);
            end
        end
        return f;
    endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// seq_det_sat_cnt: generic saturating up-counter.
//   clk      clock, posedge
//   clk_rst  synchronous active-high reset
//   en       increment request
//   clr      synchronous clear, wins over en
//   cnt      current count, sticks at all-ones
module seq_det_sat_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clk_rst,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clk_rst) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: KMP-style detector for a compile-time PAT_W-bit pattern
// on a qualified serial stream, with run-time overlap selection.
//   clk, clk_rst   clock and synchronous active-high reset
//   en, x          sample qualifier and serial data bit
//   overlap_en     1: keep border after a match; 0: restart at 0
//   clr            soft clear of progress (and counter)
//   match          registered one-cycle pulse per completed pattern
//   prog           matched prefix length 0..PAT_W-1
//   match_cnt      saturating match count
// Build option: define SEQDET_MATCH_CNT_EN to build the match counter;
// otherwise match_cnt is tied to 0.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = 3,
    parameter logic [PAT_W-1:0] PATTERN = 3'b110,
    parameter int               CNT_W   = 8
) (
    input  logic                              clk,
    input  logic                              clk_rst,
    input  logic                              en,
    input  logic                              x,
    input  logic                              overlap_en,
    input  logic                              clr,
    output logic                              match,
    output logic [seq_det_prog_w(PAT_W)-1:0]  prog,
    output logic [CNT_W-1:0]                  match_cnt
);

    localparam int               SW       = seq_det_prog_w(PAT_W);
    localparam logic [31:0]      PAT_ORD  = seq_det_order(PAT_W_MAX'(PATTERN), PAT_W);
    localparam fail_tbl_t        FAIL     = seq_det_fail(PAT_W_MAX'(PATTERN), PAT_W);
    localparam logic [IDX_W-1:0] PAT_W_I  = IDX_W'(PAT_W);
    localparam logic [IDX_W-1:0] FAIL_END = FAIL[PAT_W];

    logic [SW-1:0]    s_q, s_d;
    logic             match_q, match_d;
    logic [IDX_W-1:0] cur, t;
    logic             done;

    // Candidate next prefix length: walk the failure chain from s until the
    // expected bit agrees with x or we fall back to the empty prefix. Each
    // step strictly shrinks cur, so PAT_W iterations always suffice.
    always_comb begin
        cur  = IDX_W'(s_q);
        t    = '0;
        done = 1'b0;
        for (int i = 0; i < PAT_W; i++) begin
            if (!done) begin
                if (PAT_ORD[cur] == x) begin
                    t    = cur + IDX_W'(1);
                    done = 1'b1;
                end else if (cur == '0) begin
                    t    = '0;
                    done = 1'b1;
                end else begin
                    cur = FAIL[cur];
                end
            end
        end
    end

    always_comb begin
        s_d     = s_q;
        match_d = 1'b0;
        if (clr) begin
            s_d = '0;
        end else if (en) begin
            if (t == PAT_W_I) begin
                match_d = 1'b1;
                s_d     = overlap_en ? SW'(FAIL_END) : '0;
            end else begin
                s_d = SW'(t);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clk_rst) begin
            s_q     <= '0;
            match_q <= 1'b0;
        end else begin
            s_q     <= s_d;
            match_q <= match_d;
        end
    end

    assign match = match_q;
    assign prog  = s_q;

`ifdef SEQDET_MATCH_CNT_EN
    // match_d already excludes clr, so the counter sees exactly the pulses.
    seq_det_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk     (clk),
        .clk_rst (clk_rst),
        .en      (match_d),
        .clr     (clr),
        .cnt     (match_cnt)
    );
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       clk_rst = 1'b1, en = 1'b0, x = 1'b0, overlap_en = 1'b1, clr = 1'b0;
    logic       match_a, match_b;
    logic [1:0] prog_a;
    logic [2:0] prog_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    int n_assert = 0;
    int n_fail   = 0;

`ifdef SEQDET_MATCH_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    seq_detector_param dut_a (
        .clk(clk), .clk_rst(clk_rst), .en(en), .x(x), .overlap_en(overlap_en),
        .clr(clr), .match(match_a), .prog(prog_a), .match_cnt(cnt_a));

    seq_detector_param #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(2)) dut_b (
        .clk(clk), .clk_rst(clk_rst), .en(en), .x(x), .overlap_en(overlap_en),
        .clr(clr), .match(match_b), .prog(prog_b), .match_cnt(cnt_b));

    // Reference model: keep the consumed bit history since the last restart and
    // test pattern membership directly on that string.
    typedef struct {
        logic [63:0] hist;
        int          len;
        bit          match;
        int          prog;
        int          cnt;
    } mdl_t;

    mdl_t ma = '{hist: '0, len: 0, match: 0, prog: 0, cnt: 0};
    mdl_t mb = '{hist: '0, len: 0, match: 0, prog: 0, cnt: 0};

    // last k history bits equal the first k pattern bits
    function automatic bit sfx_eq(logic [63:0] h, int k, int pw, logic [15:0] pat);
        for (int i = 0; i < k; i++)
            if (h[k-1-i] !== pat[pw-1-i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic mdl_t step(mdl_t m, int pw, logic [15:0] pat, int cw,
                                  bit r_, bit c_, bit e_, bit x_, bit o_);
        mdl_t r;
        r = m;
        r.match = 1'b0;
        if (r_) begin
            r.hist = '0; r.len = 0; r.cnt = 0;
        end else if (c_) begin
            r.len = 0; r.cnt = 0;
        end else if (e_) begin
            r.hist = {r.hist[62:0], x_};
            if (r.len < 63) r.len++;
            if (r.len >= pw && sfx_eq(r.hist, pw, pw, pat)) begin
                r.match = 1'b1;
                if (r.cnt < (1 << cw) - 1) r.cnt++;
                if (!o_) r.len = 0;
            end
        end
        r.prog = 0;
        for (int k = 1; k < pw; k++)
            if (k <= r.len && sfx_eq(r.hist, k, pw, pat)) r.prog = k;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic cyc(input bit r_, input bit c_, input bit e_, input bit x_, input bit o_);
        @(negedge clk);
        clk_rst = r_; clr = c_; en = e_; x = x_; overlap_en = o_;
        @(posedge clk);
        ma = step(ma, 3, 16'b110,  8, r_, c_, e_, x_, o_);
        mb = step(mb, 4, 16'b1011, 2, r_, c_, e_, x_, o_);
        #1;
        chk("a_match", 32'(match_a), 32'(ma.match));
        chk("a_prog",  32'(prog_a),  32'(ma.prog));
        chk("a_cnt",   32'(cnt_a),   CNT_ON ? 32'(ma.cnt) : 32'd0);
        chk("b_match", 32'(match_b), 32'(mb.match));
        chk("b_prog",  32'(prog_b),  32'(mb.prog));
        chk("b_cnt",   32'(cnt_b),   CNT_ON ? 32'(mb.cnt) : 32'd0);
    endtask

    task automatic feed(input string s, input bit o_);
        for (int i = 0; i < s.len(); i++) cyc(1'b0, 1'b0, 1'b1, s[i] == "1", o_);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        // reset state
        do_reset();
        do_reset();
        chk("rst_match", 32'(match_a), 32'd0);
        chk("rst_prog",  32'(prog_a),  32'd0);

        // 110 detector: 0,1,1,0
        feed("011", 1'b1);
        chk("p110_prog2", 32'(prog_a), 32'd2);
        feed("0", 1'b1);
        chk("p110_match", 32'(match_a), 32'd1);
        chk("p110_cnt",   32'(cnt_a),   CNT_ON ? 32'd1 : 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("p110_one_cycle", 32'(match_a), 32'd0);

        // 1011 overlapping: pulses after bits 4 and 7
        do_reset();
        feed("1011", 1'b1);
        chk("ov_first", 32'(match_b), 32'd1);
        feed("011", 1'b1);
        chk("ov_second", 32'(match_b), 32'd1);
        chk("ov_cnt",    32'(cnt_b),   CNT_ON ? 32'd2 : 32'd0);

        // 1011 non-overlapping: single pulse, final prog 1
        do_reset();
        feed("1011011", 1'b0);
        chk("nov_nomatch", 32'(match_b), 32'd0);
        chk("nov_prog",    32'(prog_b),  32'd1);

        // en gaps: prog holds while idle
        do_reset();
        feed("1", 1'b1);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("gap_hold", 32'(prog_a), 32'd1);
        feed("1", 1'b1);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        feed("0", 1'b1);
        chk("gap_match", 32'(match_a), 32'd1);

        // saturation on the 2-bit counter, then clr
        do_reset();
        feed("1011011011011011", 1'b1);
        chk("sat_cnt", 32'(cnt_b), CNT_ON ? 32'd3 : 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("clr_cnt",  32'(cnt_b),  32'd0);
        chk("clr_prog", 32'(prog_b), 32'd0);

        // clr coincident with completing bit
        do_reset();
        feed("11", 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("clr_win_match", 32'(match_a), 32'd0);
        chk("clr_win_cnt",   32'(cnt_a),   32'd0);

        // reset mid-pattern
        do_reset();
        feed("11", 1'b1);
        do_reset();
        chk("midrst_prog", 32'(prog_a), 32'd0);
        feed("0", 1'b1);
        chk("midrst_nomatch", 32'(match_a), 32'd0);
        feed("110", 1'b1);
        chk("midrst_match", 32'(match_a), 32'd1);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            cyc($urandom_range(99) == 0, $urandom_range(29) == 0,
                $urandom_range(3) != 0, 1'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
